// File: rtl/packet_serializer.sv
// Latches one outgoing packet and streams it byte-wise over a valid/ready port once okToSend grants the slot.
// Optional: define PKT_CHECKSUM_EN to append an XOR checksum byte (bytes 1..16) as byte 17.
module packet_serializer #(
  parameter int                   WORD_WIDTH = 16,
  parameter int                   MEM_WIDTH  = 8,
  parameter logic [MEM_WIDTH-1:0] PREAMBLE   = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  okToSend,
  input  logic [2:0]            rPacketType,
  input  logic [WORD_WIDTH-1:0] rSourceID,
  input  logic [WORD_WIDTH-1:0] rDestinationID,
  input  logic [WORD_WIDTH-1:0] rSourceHops,
  input  logic [WORD_WIDTH-1:0] rQValue,
  input  logic [WORD_WIDTH-1:0] rEnergyLeft,
  input  logic [WORD_WIDTH-1:0] rChosenCH,
  input  logic [WORD_WIDTH-1:0] rHopsFromCH,
  input  logic [5:0]            rTimeslot,
  output logic [MEM_WIDTH-1:0]  tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  tx_done,
  output logic                  overrun
);

  localparam int NUM_WORDS = 7;
`ifdef PKT_CHECKSUM_EN
  localparam int NUM_BYTES = 18;
`else
  localparam int NUM_BYTES = 17;
`endif
  localparam logic [4:0] LAST_IDX = 5'(NUM_BYTES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_SLOT, SEND, DONE} stateType;

  stateType              stateReg, stateNext;
  logic [2:0]            typeReg;
  logic [5:0]            slotReg;
  logic [WORD_WIDTH-1:0] wordIn  [NUM_WORDS];
  logic [WORD_WIDTH-1:0] wordReg [NUM_WORDS];
  logic [MEM_WIDTH-1:0]  pktBytes [NUM_BYTES];
  logic [4:0]            idxReg;
  logic [4:0]            idxNext;
  logic [MEM_WIDTH-1:0]  txDataReg;
  logic                  txValidReg;
  logic                  overrunReg;
  logic                  acceptByte;
  logic                  lastAccept;

  assign wordIn[0] = rSourceID;
  assign wordIn[1] = rDestinationID;
  assign wordIn[2] = rSourceHops;
  assign wordIn[3] = rQValue;
  assign wordIn[4] = rEnergyLeft;
  assign wordIn[5] = rChosenCH;
  assign wordIn[6] = rHopsFromCH;

  // Packet image is built from the latched fields, which only change in IDLE.
  always_comb begin
    logic [MEM_WIDTH-1:0] chk;
    pktBytes[0] = PREAMBLE;
    pktBytes[1] = {{(MEM_WIDTH-3){1'b0}}, typeReg};
    for (int i = 0; i < NUM_WORDS; i++) begin
      pktBytes[2 + 2*i] = wordReg[i][WORD_WIDTH-1 -: MEM_WIDTH];
      pktBytes[3 + 2*i] = wordReg[i][MEM_WIDTH-1:0];
    end
    pktBytes[16] = {{(MEM_WIDTH-6){1'b0}}, slotReg};
    chk = '0;
    for (int i = 1; i <= 16; i++) begin
      chk = chk ^ pktBytes[i];
    end
`ifdef PKT_CHECKSUM_EN
    pktBytes[17] = chk;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stateReg <= IDLE;
    else     stateReg <= stateNext;
  end

  always_comb begin
    stateNext  = stateReg;
    acceptByte = txValidReg & tx_ready;
    lastAccept = acceptByte && (idxReg == LAST_IDX);
    busy       = (stateReg != IDLE);
    tx_done    = (stateReg == DONE);
    case (stateReg)
      IDLE:      if (load)       stateNext = WAIT_SLOT;
      WAIT_SLOT: if (okToSend)   stateNext = SEND;
      SEND:      if (lastAccept) stateNext = DONE;
      DONE:                      stateNext = IDLE;
      default:                   stateNext = IDLE;
    endcase
  end

  assign idxNext = idxReg + 5'd1;

  // First cycle of SEND only primes the output register, so tx_valid is purely registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      typeReg    <= '0;
      slotReg    <= '0;
      for (int i = 0; i < NUM_WORDS; i++) wordReg[i] <= '0;
      idxReg     <= '0;
      txDataReg  <= '0;
      txValidReg <= 1'b0;
      overrunReg <= 1'b0;
    end else begin
      if (load && stateReg == IDLE) begin
        typeReg <= rPacketType;
        slotReg <= rTimeslot;
        for (int i = 0; i < NUM_WORDS; i++) wordReg[i] <= wordIn[i];
      end
      if (load && stateReg != IDLE) overrunReg <= 1'b1;
      if (stateReg == WAIT_SLOT) idxReg <= '0;
      if (stateReg == SEND) begin
        if (!txValidReg) begin
          txValidReg <= 1'b1;
          txDataReg  <= pktBytes[idxReg];
        end else if (tx_ready) begin
          if (idxReg == LAST_IDX) begin
            txValidReg <= 1'b0;
            txDataReg  <= '0;
          end else begin
            idxReg    <= idxNext;
            txDataReg <= pktBytes[idxNext];
          end
        end
      end
    end
  end

  assign tx_data  = txDataReg;
  assign tx_valid = txValidReg;
  assign overrun  = overrunReg;

endmodule
